// File: rtl/serial_feeder.sv
// serial_feeder: parallel-to-serial shifter feeding a bit-serial consumer.
// Accepts a word plus a bit length over a valid/ready handshake and sends the
// word MSB first, one bit per clock. Back-to-back words run with no gap.
// Optional feature: define FEEDER_REPEAT_EN to add the rpt input, which restarts
// the latched word at its last bit when no new word is accepted.
module serial_feeder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
`ifdef FEEDER_REPEAT_EN
  input  logic             rpt,
`endif
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [5:0]       load_len,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;     // current bit always sits in the MSB
  logic [CW-1:0]    cnt;       // index of the bit on dout
  logic [CW-1:0]    last_idx;  // N-1 for the word in flight
  logic [CW-1:0]    new_last;  // N-1 for the word offered on load_*
  logic             last_bit;
  logic             accept;
`ifdef FEEDER_REPEAT_EN
  logic [WIDTH-1:0] word_q;    // untouched copy of the word for restarting
`endif

  // Effective length: 0 or anything longer than the register means a full word.
  always_comb begin
    // NOTE: give every combinational output a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    new_last = CW'(WIDTH - 1);
    if (load_len != 6'd0 && 32'(load_len) <= WIDTH)
      new_last = CW'(32'(load_len) - 32'd1);
  end

  // done is registered and is only ever set while shifting, so it marks the
  // last-bit cycle; load_ready is derived from flops only, not from load_valid.
  assign last_bit   = (state == SHIFT) && done;
  assign load_ready = (state == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  assign busy       = (state == SHIFT);
  assign dout_valid = (state == SHIFT);
  assign dout       = shreg[WIDTH-1];

  // Control FSM plus datapath: accept, shift, finish, optional restart.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      last_idx <= '0;
      done     <= 1'b0;
`ifdef FEEDER_REPEAT_EN
      word_q   <= '0;
`endif
    end else if (accept) begin
      state    <= SHIFT;
      shreg    <= load_data;
      cnt      <= '0;
      last_idx <= new_last;
      done     <= (new_last == '0);
`ifdef FEEDER_REPEAT_EN
      word_q   <= load_data;
`endif
    end else if (state == SHIFT) begin
      if (last_bit) begin
`ifdef FEEDER_REPEAT_EN
        if (rpt) begin
          shreg <= word_q;
          cnt   <= '0;
          done  <= (last_idx == '0);
        end else begin
          state <= IDLE;
          shreg <= '0;
          cnt   <= '0;
          done  <= 1'b0;
        end
`else
        state <= IDLE;
        shreg <= '0;
        cnt   <= '0;
        done  <= 1'b0;
`endif
      end else begin
        shreg <= shreg << 1;
        cnt   <= cnt + 1'b1;
        done  <= ((cnt + 1'b1) == last_idx);
      end
    end
  end

endmodule

// File: tb/tb_serial_feeder.sv
// tb_serial_feeder: directed and randomized checks of serial_feeder against a
// queue-of-bits reference model. Define FEEDER_REPEAT_EN to cover rpt as well.
module tb_serial_feeder;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_data;
  logic [5:0]   load_len;
  logic         dout;
  logic         dout_valid;
  logic         busy;
  logic         done;
`ifdef FEEDER_REPEAT_EN
  logic         rpt;
`endif

  always #5 clk = ~clk;

  serial_feeder #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef FEEDER_REPEAT_EN
    .rpt        (rpt),
`endif
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_len   (load_len),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done)
  );

  // Reference model: the bits still to appear on dout, front = current cycle.
  typedef struct packed {
    logic b;
    logic last;
  } item_t;

  item_t        q[$];
  logic [W-1:0] m_word;
  int           m_n;

  int n_checks = 0;
  int n_bad    = 0;

  // Observation accumulators for directed scenarios.
  logic [31:0] obs_bits;
  int          n_valid;
  int          n_done;
  int          n_idle;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int eff_len(input logic [5:0] l);
    return (l == 6'd0 || int'(l) > W) ? W : int'(l);
  endfunction

  task automatic push_word(input logic [W-1:0] d, input int n);
    item_t it;
    for (int i = 0; i < n; i++) begin
      it.b    = d[W-1-i];
      it.last = (i == n - 1);
      q.push_back(it);
    end
  endtask

  task automatic clear_obs();
    obs_bits = '0;
    n_valid  = 0;
    n_done   = 0;
    n_idle   = 0;
  endtask

  // One clock: update the model at the rising edge, check outputs at the falling edge.
  task automatic step();
    logic acc;
    logic e_dout, e_valid, e_done, e_ready;
`ifdef FEEDER_REPEAT_EN
    logic was_last;
`endif
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      acc = load_valid && (q.size() <= 1);
`ifdef FEEDER_REPEAT_EN
      was_last = (q.size() > 0) && q[0].last;
`endif
      if (q.size() > 0) void'(q.pop_front());
      if (acc) begin
        m_word = load_data;
        m_n    = eff_len(load_len);
        push_word(m_word, m_n);
      end
`ifdef FEEDER_REPEAT_EN
      else if (was_last && rpt) push_word(m_word, m_n);
`endif
    end
    @(negedge clk);
    if (q.size() > 0) begin
      e_dout  = q[0].b;
      e_valid = 1'b1;
      e_done  = q[0].last;
      e_ready = (q.size() == 1);
    end else begin
      e_dout  = 1'b0;
      e_valid = 1'b0;
      e_done  = 1'b0;
      e_ready = 1'b1;
    end
    check("dout",       32'(dout),       32'(e_dout));
    check("dout_valid", 32'(dout_valid), 32'(e_valid));
    check("busy",       32'(busy),       32'(e_valid));
    check("done",       32'(done),       32'(e_done));
    check("load_ready", 32'(load_ready), 32'(e_ready));
    if (dout_valid) begin
      obs_bits = {obs_bits[30:0], dout};
      n_valid++;
    end
    if (done) n_done++;
    if (!busy) n_idle++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input logic [W-1:0] d, input logic [5:0] l);
    load_data  = d;
    load_len   = l;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  // Advance until the model says the current cycle carries a last bit (bounded).
  task automatic wait_last(input string tag);
    for (int i = 0; i < 64 && q.size() != 1; i++) step();
    check(tag, q.size(), 1);
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    load_len   = '0;
`ifdef FEEDER_REPEAT_EN
    rpt        = 1'b0;
`endif
    clear_obs();
    steps(2);
    check("reset_ready", 32'(load_ready), 32'd1);
    check("reset_busy",  32'(busy),       32'd0);
    rst = 1'b0;
    steps(2);

    // Full 32-bit word, then back to idle.
    clear_obs();
    load(32'hC646A4A2, 6'd32);
    steps(31);
    check("w32_bits",  obs_bits, 32'hC646A4A2);
    check("w32_valid", n_valid, 32'd32);
    check("w32_done",  n_done,  32'd1);
    check("w32_last_done", 32'(done), 32'd1);
    step();
    check("w32_idle_busy", 32'(busy), 32'd0);

    // Short word of 4 bits.
    clear_obs();
    load(32'hA0000000, 6'd4);
    steps(3);
    check("w4_bits", obs_bits[3:0], 32'hA);
    check("w4_done", n_done, 32'd1);
    steps(3);
    check("w4_valid", n_valid, 32'd4);

    // Length 0 and length 40 both mean a full word.
    for (int k = 0; k < 2; k++) begin
      logic [W-1:0] d;
      d = $urandom;
      clear_obs();
      load(d, (k == 0) ? 6'd0 : 6'd40);
      steps(40);
      check(k == 0 ? "len0_valid" : "len40_valid", n_valid, 32'd32);
      check(k == 0 ? "len0_bits"  : "len40_bits",  obs_bits, d);
      check(k == 0 ? "len0_done"  : "len40_done",  n_done, 32'd1);
    end

    // Back-to-back words accepted in the last-bit cycle.
    clear_obs();
    load(32'hF0000000, 6'd4);
    wait_last("b2b_wait");
    load(32'h50000000, 6'd4);
    steps(3);
    check("b2b_bits", obs_bits[7:0], 32'hF5);
    check("b2b_done", n_done, 32'd2);
    check("b2b_gap",  n_idle, 32'd0);
    step();

    // Offers while not ready are ignored and leave the word intact.
    clear_obs();
    load(32'hA5A5A5A5, 6'd8);
    load_data  = 32'hFFFFFFFF;
    load_len   = 6'd3;
    load_valid = 1'b1;
    steps(3);
    load_valid = 1'b0;
    steps(8);
    check("ign_bits",  obs_bits[7:0], 32'hA5);
    check("ign_valid", n_valid, 32'd8);

    // Reset on the tenth bit of a word, with a simultaneous offer.
    clear_obs();
    load($urandom, 6'd32);
    steps(9);
    rst        = 1'b1;
    load_valid = 1'b1;
    load_data  = 32'h0F0F0F0F;
    load_len   = 6'd8;
    step();
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_dout",  32'(dout),       32'd0);
    check("rst_ready", 32'(load_ready), 32'd1);
    rst        = 1'b0;
    load_valid = 1'b0;
    steps(3);
    check("rst_no_done", n_done, 32'd0);
    clear_obs();
    load(32'h12345678, 6'd32);
    steps(32);
    check("post_rst_bits", obs_bits, 32'h12345678);
    check("post_rst_done", n_done, 32'd1);

`ifdef FEEDER_REPEAT_EN
    // Repeat mode: the word restarts until rpt drops.
    rpt = 1'b1;
    clear_obs();
    load(32'h90000000, 6'd4);
    steps(11);
    check("rpt_bits", obs_bits[11:0], 32'h999);
    check("rpt_done", n_done, 32'd3);
    rpt = 1'b0;
    steps(2);
    check("rpt_stop", 32'(busy), 32'd0);
`endif

    // Randomized traffic, mostly short words to hit the boundaries often.
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      load_valid = $urandom_range(0, 1) == 1;
      load_data  = $urandom;
      load_len   = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                               : 6'($urandom_range(1, 8));
`ifdef FEEDER_REPEAT_EN
      rpt        = $urandom_range(0, 2) == 0;
`endif
      step();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
